// File: rtl/data_mem_bus_pkg.sv
// Shared types for the data memory bus: access size encodings, handshake FSM states
// and the latched request record.
package data_mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/data_mem_bus_lane.sv
// dmem_lane: combinational little-endian lane steering for stores (byte mask,
// replicated data) and loads (lane extraction with sign/zero extension).
module dmem_lane
    import data_mem_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        wmask     = '1;
        wdata_sh  = wdata;
        rdata_ext = rword;
        rbyte     = rword[8*addr_lo +: 8];
        rhalf     = rword[16*addr_lo[1] +: 16];
        case (size)
            SZ_BYTE: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & rhalf[15]}}, rhalf};
            end
            // word, and the reserved encoding, use the full aligned word
            default: begin
                wmask     = '1;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_bus.sv
// Data memory behind a valid/ready request/response handshake with optional wait
// states. Define DMEM_CHECK_EN to fault misaligned and out-of-range accesses.
module data_mem_bus
    import data_mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    dmem_state_t state, state_nx;
    dmem_req_t   req_q, cur;
    logic [3:0]  cnt_q;
    logic [31:0] mem [DEPTH];
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]  wmask;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;
    logic        fault;
    logic        accept;
    logic        enter_resp;
    logic        unused_addr_bits;

    // With no wait states the access happens on the accept edge, so the
    // incoming request is used directly instead of the latched copy.
    always_comb begin
        cur = req_q;
        if (state == ST_IDLE) begin
            cur.write       = req_write;
            cur.size        = req_size;
            cur.is_unsigned = req_unsigned;
            cur.addr        = req_addr;
            cur.wdata       = req_wdata;
        end
    end

    assign idx              = cur.addr[DEPTH_LOG2+1:2];
    assign accept           = (state == ST_IDLE) && req_valid;
    assign enter_resp       = (state_nx == ST_RESP) && (state != ST_RESP);
    assign unused_addr_bits = ^cur.addr;

`ifdef DMEM_CHECK_EN
    always_comb begin
        fault = ((cur.addr >> (DEPTH_LOG2 + 2)) != '0)
              || (cur.size == SZ_RSVD)
              || ((cur.size == SZ_HALF) && cur.addr[0])
              || ((cur.size == SZ_WORD) && (cur.addr[1:0] != 2'b00));
    end
`else
    assign fault = 1'b0;
`endif

    dmem_lane u_lane (
        .size        (cur.size),
        .addr_lo     (cur.addr[1:0]),
        .is_unsigned (cur.is_unsigned),
        .wdata       (cur.wdata),
        .rword       (mem[idx]),
        .wmask       (wmask),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = (WAIT_CYCLES != 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                if (cnt_q == '0)
                    state_nx = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_q <= cur;
                cnt_q <= 4'(WAIT_CYCLES - 1);
            end else if (state == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                resp_rdata_q <= (cur.write || fault) ? '0 : rdata_ext;
                resp_err_q   <= fault;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (enter_resp && cur.write && !fault) begin
            for (int unsigned b = 0; b < 4; b++)
                if (wmask[b])
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// Directed bench for data_mem_bus: a zero-wait instance for data paths and a
// three-wait instance for handshake timing and reset-in-flight behaviour.
module tb_data_mem_bus;
    import data_mem_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = SZ_WORD;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;

    logic        rv0 = 1'b0, rv3 = 1'b0;
    logic        rr0, rr3, vv0, vv3, er0, er3;
    logic [31:0] rd0, rd3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_bus #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rr0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vv0),
        .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0)
    );

    data_mem_bus #(.DEPTH_LOG2(8), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rr3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vv3),
        .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(er3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full transaction from IDLE with resp_ready high; lat counts edges from accept to resp_valid.
    task automatic xfer(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        resp_ready = 1'b1;
        if (sel) rv3 = 1'b1; else rv0 = 1'b1;
        @(posedge clk); #1;
        rv0 = 1'b0; rv3 = 1'b0;
        lat = 1;
        while (!(sel ? vv3 : vv0) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) check("resp_timeout", 32'(lat), 32'd0);
        rd = sel ? rd3 : rd0;
        er = sel ? er3 : er0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        #12;
        check("rst_req_ready", 32'(rr0), 32'd1);
        check("rst_resp_valid", 32'(vv0), 32'd0);
        check("rst_resp_rdata", rd0, 32'h0);
        check("rst_resp_err", 32'(er0), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        xfer(0, 0, SZ_WORD, 0, 32'h10, 32'h0, rd, er, lat);
        check("ld_w_10", rd, 32'h0);
        check("ld_w_10_err", 32'(er), 32'd0);
        check("lat_w0", 32'(lat), 32'd1);

        xfer(0, 1, SZ_WORD, 0, 32'h20, 32'h11223344, rd, er, lat);
        check("st_rdata_zero", rd, 32'h0);
        xfer(0, 1, SZ_BYTE, 0, 32'h21, 32'hFFFFFFAB, rd, er, lat);
        xfer(0, 0, SZ_WORD, 0, 32'h20, 32'h0, rd, er, lat);
        check("ld_w_20_merge", rd, 32'h1122AB44);

        xfer(0, 1, SZ_HALF, 0, 32'h32, 32'h12348001, rd, er, lat);
        xfer(0, 0, SZ_HALF, 0, 32'h32, 32'h0, rd, er, lat);
        check("ld_h_s_32", rd, 32'hFFFF8001);
        xfer(0, 0, SZ_HALF, 1, 32'h32, 32'h0, rd, er, lat);
        check("ld_h_u_32", rd, 32'h00008001);
        xfer(0, 0, SZ_BYTE, 0, 32'h33, 32'h0, rd, er, lat);
        check("ld_b_s_33", rd, 32'hFFFFFF80);
        xfer(0, 0, SZ_BYTE, 0, 32'h32, 32'h0, rd, er, lat);
        check("ld_b_s_32", rd, 32'h00000001);
        xfer(0, 0, SZ_WORD, 0, 32'h30, 32'h0, rd, er, lat);
        check("ld_w_30", rd, 32'h80010000);

`ifdef DMEM_CHECK_EN
        xfer(0, 1, SZ_WORD, 0, 32'h22, 32'h55667788, rd, er, lat);
        check("st_mis_err", 32'(er), 32'd1);
        xfer(0, 0, SZ_WORD, 0, 32'h20, 32'h0, rd, er, lat);
        check("ld_w_20_kept", rd, 32'h1122AB44);
        check("ld_w_20_kept_err", 32'(er), 32'd0);
        xfer(0, 0, SZ_WORD, 0, 32'h400, 32'h0, rd, er, lat);
        check("ld_oor_err", 32'(er), 32'd1);
        check("ld_oor_rdata", rd, 32'h0);
        check("lat_oor", 32'(lat), 32'd1);
        xfer(0, 0, SZ_HALF, 0, 32'h31, 32'h0, rd, er, lat);
        check("ld_h_mis_err", 32'(er), 32'd1);
        xfer(0, 0, SZ_RSVD, 0, 32'h20, 32'h0, rd, er, lat);
        check("ld_rsvd_err", 32'(er), 32'd1);
`else
        xfer(0, 1, SZ_WORD, 0, 32'h22, 32'h55667788, rd, er, lat);
        check("st_mis_noerr", 32'(er), 32'd0);
        xfer(0, 0, SZ_WORD, 0, 32'h20, 32'h0, rd, er, lat);
        check("ld_w_20_aligned", rd, 32'h55667788);
        xfer(0, 0, SZ_WORD, 0, 32'h420, 32'h0, rd, er, lat);
        check("ld_alias_420", rd, 32'h55667788);
        check("ld_alias_err", 32'(er), 32'd0);
        xfer(0, 0, SZ_RSVD, 0, 32'h20, 32'h0, rd, er, lat);
        check("ld_rsvd_word", rd, 32'h55667788);
        xfer(0, 0, SZ_HALF, 1, 32'h23, 32'h0, rd, er, lat);
        check("ld_h_mis_hi", rd, 32'h00005566);
`endif

        xfer(1, 1, SZ_WORD, 0, 32'h50, 32'hCAFEF00D, rd, er, lat);
        check("lat_w3", 32'(lat), 32'd4);

        req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h50;
        resp_ready = 1'b0;
        rv3 = 1'b1;
        check("w3_ready_idle", 32'(rr3), 32'd1);
        @(posedge clk); #1;
        rv3 = 1'b0;
        lat = 1;
        while (!vv3 && lat < 50) begin
            check("w3_ready_wait", 32'(rr3), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("w3_hold_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("w3_hold_valid", 32'(vv3), 32'd1);
            check("w3_hold_rdata", rd3, 32'hCAFEF00D);
            check("w3_hold_ready", 32'(rr3), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("w3_release_valid", 32'(vv3), 32'd0);
        check("w3_release_ready", 32'(rr3), 32'd1);

        xfer(1, 1, SZ_WORD, 0, 32'h40, 32'h11111111, rd, er, lat);
        req_write = 1'b1; req_size = SZ_WORD; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        rv3 = 1'b1;
        @(posedge clk); #1;
        rv3 = 1'b0;
        check("inflight_ready", 32'(rr3), 32'd0);
        reset = 1'b1;
        #2;
        check("post_rst_ready", 32'(rr3), 32'd1);
        check("post_rst_valid", 32'(vv3), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        xfer(1, 0, SZ_WORD, 0, 32'h40, 32'h0, rd, er, lat);
        check("ld_40_after_rst", rd, 32'h0);
        xfer(0, 0, SZ_WORD, 0, 32'h30, 32'h0, rd, er, lat);
        check("ld_30_after_rst", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
